led_activity_scheduler: RTL

- Shares one status LED between NUM_CH activity sources (frame valid, USB traffic, I2C, etc.).
- Each falling edge on a source marks that channel pending.
- A round-robin scheduler grants one pending channel at a time and plays a blink code on the LED: (channel index + 1) pulses, then an inter-code gap.
- Sits next to the board LED pins, alongside the per-line activity counters.

---
 rtl/led_activity_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/led_activity_scheduler.sv
// Shares one status LED between NUM_CH activity lines. A falling edge on a
// line marks it pending; a round-robin scheduler then plays a blink code of
// (channel index + 1) pulses followed by an inter-code gap.
module led_activity_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int TICK_DIV    = 1000000,
  parameter int PULSE_TICKS = 2,
  parameter int GAP_TICKS   = 6,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig,
  input  logic              enable,
  output logic              led,
  output logic              busy,
  output logic [CH_W-1:0]   active_ch,
  output logic [NUM_CH-1:0] pending
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]        state;
  logic [NUM_CH-1:0] sig_d;
  logic [NUM_CH-1:0] events;
  logic [NUM_CH-1:0] pending_nxt;
  logic [NUM_CH-1:0] clr_mask;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant_ch;
  logic              found;
  logic              grant;
  logic [PW-1:0]     prescaler;
  logic              tick;
  logic [TW-1:0]     tcnt;
  logic [CH_W:0]     pulses_left;

  assign events   = sig_d & ~sig;
  assign tick     = (prescaler == PW'(TICK_DIV - 1));
  assign grant    = (state == S_IDLE) && enable && (|pending);
  assign clr_mask = NUM_CH'(1) << grant_ch;

  // Round-robin search: channels above last_grant first, then wrap to the low ones.
  always_comb begin
    found    = 1'b0;
    grant_ch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && pending[i] && (i > 32'(last_grant))) begin
        found    = 1'b1;
        grant_ch = CH_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && pending[i] && (i <= 32'(last_grant))) begin
        found    = 1'b1;
        grant_ch = CH_W'(i);
      end
    end
  end

  // Clear the granted flag first so a same-cycle event on that channel wins.
  always_comb begin
    pending_nxt = pending;
    if (grant) pending_nxt = pending_nxt & ~clr_mask;
    pending_nxt = pending_nxt | events;
  end

  // Edge-detect history and pending flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d   <= '0;
      pending <= '0;
    end else begin
      sig_d   <= sig;
      pending <= pending_nxt;
    end
  end

  // Tick prescaler, re-phased on every grant so phases are whole ticks.
  always_ff @(posedge clk) begin
    if (rst || grant || tick) prescaler <= '0;
    else                      prescaler <= prescaler + 1'b1;
  end

  // Blink-code sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      led         <= 1'b0;
      busy        <= 1'b0;
      active_ch   <= '0;
      last_grant  <= CH_W'(NUM_CH - 1);
      pulses_left <= '0;
      tcnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            active_ch   <= grant_ch;
            last_grant  <= grant_ch;
            led         <= 1'b1;
            busy        <= 1'b1;
            pulses_left <= {1'b0, grant_ch};
            tcnt        <= '0;
            state       <= S_ON;
          end
        end
        S_ON: begin
          if (tick) begin
            if (tcnt == TW'(PULSE_TICKS - 1)) begin
              tcnt <= '0;
              led  <= 1'b0;
              if (pulses_left == '0) begin
                state <= S_GAP;
              end else begin
                state       <= S_OFF;
                pulses_left <= pulses_left - 1'b1;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_OFF: begin
          if (tick) begin
            if (tcnt == TW'(PULSE_TICKS - 1)) begin
              tcnt  <= '0;
              led   <= 1'b1;
              state <= S_ON;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (tcnt == TW'(GAP_TICKS - 1)) begin
              tcnt  <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
